// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the initiator state encoding.
package wb_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  // Initiator phases: waiting for a command, bus cycle in flight, response held.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timer.sv
// Clear/enable up-counter with a parameterised terminal count.
// o_expired pulses on the enabled edge at which the count reaches TERMINAL,
// so a caller acting on it leaves exactly TERMINAL enabled edges after a clear.
module wb_timer #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TERMINAL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear dominates, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && !i_clear && (count_q == LAST);

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out, with a no-ack timeout that aborts the cycle with error.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [WB_ADR_W-1:0] i_cmd_adr,
  input  logic [WB_DAT_W-1:0] i_cmd_dat,
  input  logic [WB_SEL_W-1:0] i_cmd_sel,
  input  logic                i_cmd_we,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WB_DAT_W-1:0] o_rsp_dat,
  output logic                o_rsp_err,
  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic                o_wb_we,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_ack
);

  wb_state_e             state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  cyc_q, cyc_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  wb_timer #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (timer_clear),
    .i_enable  (timer_enable),
    .o_expired (timer_expired)
  );

  // Transfer sequencing; every output is computed one edge ahead and registered.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_err_d    = rsp_err_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_d     = ST_BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          adr_d       = i_cmd_adr;
          dat_d       = i_cmd_dat;
          sel_d       = i_cmd_sel;
          we_d        = i_cmd_we;
          timer_clear = 1'b1;
        end
      end
      ST_BUS: begin
        timer_enable = !i_wb_ack;
        // An ack on the timeout edge masks the timer, so ack always wins.
        if (i_wb_ack) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : i_wb_dat;
          rsp_err_d   = 1'b0;
        end else if (timer_expired) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight or pending transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: two instances (default timeout and timeout 4),
// a memory-backed responder with programmable ack latency, a transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_wb_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel_b;
  logic        cmd_valid, rsp_ready, stray_ack, resp_ack, ack_in;
  logic [31:0] cmd_adr, cmd_dat, wb_rdat;
  logic [3:0]  cmd_sel;
  logic        cmd_we;
  int          ack_at;

  assign ack_in = resp_ack | stray_ack;

  logic        a_ready, a_rvalid, a_rerr, a_cyc, a_stb, a_we;
  logic [31:0] a_rdat, a_adr, a_dat;
  logic [3:0]  a_sel;
  logic        b_ready, b_rvalid, b_rerr, b_cyc, b_stb, b_we;
  logic [31:0] b_rdat, b_adr, b_dat;
  logic [3:0]  b_sel;

  wb_initiator u_dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid & ~sel_b), .o_cmd_ready(a_ready),
    .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel), .i_cmd_we(cmd_we),
    .o_rsp_valid(a_rvalid), .i_rsp_ready(rsp_ready & ~sel_b),
    .o_rsp_dat(a_rdat), .o_rsp_err(a_rerr),
    .o_wb_adr(a_adr), .o_wb_dat(a_dat), .o_wb_sel(a_sel), .o_wb_we(a_we),
    .o_wb_cyc(a_cyc), .o_wb_stb(a_stb),
    .i_wb_dat(wb_rdat), .i_wb_ack(ack_in & ~sel_b)
  );

  wb_initiator #(.TIMEOUT_CYCLES(4)) u_dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid & sel_b), .o_cmd_ready(b_ready),
    .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel), .i_cmd_we(cmd_we),
    .o_rsp_valid(b_rvalid), .i_rsp_ready(rsp_ready & sel_b),
    .o_rsp_dat(b_rdat), .o_rsp_err(b_rerr),
    .o_wb_adr(b_adr), .o_wb_dat(b_dat), .o_wb_sel(b_sel), .o_wb_we(b_we),
    .o_wb_cyc(b_cyc), .o_wb_stb(b_stb),
    .i_wb_dat(wb_rdat), .i_wb_ack(ack_in & sel_b)
  );

  logic        o_ready, o_rvalid, o_rerr, o_cyc, o_stb, o_we;
  logic [31:0] o_rdat, o_adr, o_dat;
  logic [3:0]  o_sel;
  assign o_ready  = sel_b ? b_ready  : a_ready;
  assign o_rvalid = sel_b ? b_rvalid : a_rvalid;
  assign o_rerr   = sel_b ? b_rerr   : a_rerr;
  assign o_rdat   = sel_b ? b_rdat   : a_rdat;
  assign o_cyc    = sel_b ? b_cyc    : a_cyc;
  assign o_stb    = sel_b ? b_stb    : a_stb;
  assign o_adr    = sel_b ? b_adr    : a_adr;
  assign o_dat    = sel_b ? b_dat    : a_dat;
  assign o_sel    = sel_b ? b_sel    : a_sel;
  assign o_we     = sel_b ? b_we     : a_we;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cyc_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is either in flight (with its age in bus
  // cycles) or its response sits in a one-deep queue until consumed.
  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  bit          m_busy;
  int          m_age;
  rsp_t        m_q[$];
  logic [31:0] m_adr, m_dat, m_rdat;
  logic [3:0]  m_sel;
  logic        m_we, m_err;

  initial begin
    rsp_t r;
    int   limit;
    m_busy = 1'b0; m_age = 0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
    m_rdat = '0; m_err = 1'b0;
    forever begin
      @(posedge clk);
      limit = sel_b ? 4 : 255;
      if (rst) begin
        m_busy = 1'b0; m_age = 0; m_q.delete();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_rdat = '0; m_err = 1'b0;
      end else if (m_busy) begin
        if (ack_in) begin
          r.dat = m_we ? 32'h0 : wb_rdat;
          r.err = 1'b0;
          m_q.push_back(r);
          m_rdat = r.dat; m_err = 1'b0; m_busy = 1'b0;
        end else begin
          m_age++;
          if (m_age == limit) begin
            r.dat = 32'h0;
            r.err = 1'b1;
            m_q.push_back(r);
            m_rdat = 32'h0; m_err = 1'b1; m_busy = 1'b0;
          end
        end
      end else if (m_q.size() != 0) begin
        if (rsp_ready) void'(m_q.pop_front());
      end else if (cmd_valid) begin
        m_busy = 1'b1; m_age = 0;
        m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel; m_we = cmd_we;
      end
    end
  end

  // Per-cycle comparison of the selected DUT against the model.
  initial begin
    logic prev_cyc;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_cmd_ready", o_ready,  (!m_busy && m_q.size() == 0));
        check("m_cyc",       o_cyc,    m_busy);
        check("m_stb",       o_stb,    m_busy);
        check("m_rsp_valid", o_rvalid, (m_q.size() != 0));
        check("m_rsp_dat",   o_rdat,   m_rdat);
        check("m_rsp_err",   o_rerr,   m_err);
        check("m_wb_adr",    o_adr,    m_adr);
        check("m_wb_dat",    o_dat,    m_dat);
        check("m_wb_sel",    o_sel,    m_sel);
        check("m_wb_we",     o_we,     m_we);
        if (o_cyc && !prev_cyc) cyc_starts++;
        prev_cyc = o_cyc;
      end
    end
  end

  // Responder: counts bus cycles with stb seen and acks on the ack_at-th edge.
  logic [31:0] mem [logic [31:0]];
  initial begin
    int          stb_cnt;
    logic [31:0] v;
    stb_cnt = 0; resp_ack = 1'b0; wb_rdat = '0;
    forever begin
      @(negedge clk);
      if (o_cyc && o_stb) stb_cnt++;
      else stb_cnt = 0;
      resp_ack = (ack_at != 0) && (stb_cnt == ack_at);
      wb_rdat = '0;
      if (resp_ack) begin
        if (o_we) begin
          v = mem.exists(o_adr) ? mem[o_adr] : 32'h0;
          for (int i = 0; i < 4; i++) if (o_sel[i]) v[8*i +: 8] = o_dat[8*i +: 8];
          mem[o_adr] = v;
        end else begin
          wb_rdat = mem.exists(o_adr) ? mem[o_adr] : 32'h0;
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] s,
                      input logic we, input int ack_after,
                      output int lat, output int stb_cycles,
                      output logic [31:0] rdat, output logic rerr, output logic rcyc);
    ack_at = ack_after;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("x_ready_before", o_ready, 1'b1);
    cmd_valid = 1'b1; cmd_adr = adr; cmd_dat = dat; cmd_sel = s; cmd_we = we;
    @(posedge clk); #1;
    stb_cycles = o_stb ? 1 : 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (o_rvalid) break;
      if (o_stb) stb_cycles++;
    end
    check("x_rsp_seen", o_rvalid, 1'b1);
    rdat = o_rdat; rerr = o_rerr; rcyc = o_cyc;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("x_ready_after_consume", o_ready, 1'b1);
    check("x_rsp_valid_after_consume", o_rvalid, 1'b0);
  endtask

  initial begin
    int          lat, stbc, starts0;
    logic [31:0] rd;
    logic        re, rc;
    rst = 1'b1; sel_b = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; stray_ack = 1'b0;
    cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_we = 1'b0; ack_at = 0;
    mem[32'h100] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_cyc", o_cyc, 1'b0);
    check("rst_rsp_valid", o_rvalid, 1'b0);
    check("rst_wb_adr", o_adr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back through a registered-ack responder.
    xfer(32'h0, 32'h1, 4'hF, 1'b1, 2, lat, stbc, rd, re, rc);
    check("wr_latency", lat, 2);
    check("wr_stb_cycles", stbc, 2);
    check("wr_err", re, 1'b0);
    check("wr_dat", rd, 32'h0);
    check("wr_wb_dat_held", o_dat, 32'h1);
    check("wr_wb_we_held", o_we, 1'b1);
    xfer(32'h0, 32'h0, 4'hF, 1'b0, 2, lat, stbc, rd, re, rc);
    check("rd_dat", rd, 32'h00000001);
    check("rd_err", re, 1'b0);

    // Read with wait states.
    xfer(32'h100, 32'h0, 4'hF, 1'b0, 6, lat, stbc, rd, re, rc);
    check("ws_dat", rd, 32'hDEADBEEF);
    check("ws_err", re, 1'b0);
    check("ws_latency", lat, 6);
    check("ws_stb_cycles", stbc, 6);

    // Backpressure on the response with a command waiting.
    ack_at = 2;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_adr = 32'h100; cmd_we = 1'b0; cmd_sel = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !o_rvalid; k++) begin
      @(posedge clk); #1;
    end
    check("bp_rsp_seen", o_rvalid, 1'b1);
    starts0 = cyc_starts;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_adr = 32'h0; cmd_we = 1'b0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_dat_stable", o_rdat, 32'hDEADBEEF);
      check("bp_err_stable", o_rerr, 1'b0);
      check("bp_cmd_ready", o_ready, 1'b0);
      check("bp_no_cyc", o_cyc, 1'b0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_at_R", o_ready, 1'b1);
    check("bp_cyc_at_R", o_cyc, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_accept_R1", o_cyc, 1'b1);
    check("bp_accept_adr", o_adr, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !o_rvalid; k++) begin
      @(posedge clk); #1;
    end
    check("bp2_dat", o_rdat, 32'h00000001);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_one_transfer", cyc_starts - starts0, 1);

    // Reset while the bus cycle is in flight, then a stray ack in idle.
    ack_at = 0;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_adr = 32'h300; cmd_dat = 32'h55; cmd_sel = 4'h3; cmd_we = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_cyc", o_cyc, 1'b0);
    check("mr_stb", o_stb, 1'b0);
    check("mr_rsp_valid", o_rvalid, 1'b0);
    check("mr_ready", o_ready, 1'b1);
    check("mr_wb_adr", o_adr, 32'h0);
    check("mr_wb_dat", o_dat, 32'h0);
    check("mr_wb_sel", o_sel, 4'h0);
    check("mr_wb_we", o_we, 1'b0);
    check("mr_rsp_dat", o_rdat, 32'h0);
    check("mr_rsp_err", o_rerr, 1'b0);
    @(negedge clk);
    rst = 1'b0; stray_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ready", o_ready, 1'b1);
      check("stray_rsp_valid", o_rvalid, 1'b0);
      check("stray_err", o_rerr, 1'b0);
    end
    @(negedge clk);
    stray_ack = 1'b0;

    // Switch to the instance with a 4-cycle timeout.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sel_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    xfer(32'h200, 32'h0, 4'hF, 1'b0, 0, lat, stbc, rd, re, rc);
    check("to_latency", lat, 4);
    check("to_err", re, 1'b1);
    check("to_dat", rd, 32'h0);
    check("to_cyc_low", rc, 1'b0);
    xfer(32'h100, 32'h0, 4'hF, 1'b0, 2, lat, stbc, rd, re, rc);
    check("after_to_dat", rd, 32'hDEADBEEF);
    check("after_to_err", re, 1'b0);
    xfer(32'h100, 32'h0, 4'hF, 1'b0, 4, lat, stbc, rd, re, rc);
    check("coinc_err", re, 1'b0);
    check("coinc_dat", rd, 32'hDEADBEEF);
    check("coinc_latency", lat, 4);

    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
